exu_mdu: RTL and testbench
==========================

EXU_MDU -- requirements
Module: exu_mdu

Interface
- REQ-001: Parameter XLEN, default 32, operand and result width; SHALL be even and at least 8.
- REQ-002: Parameter CNT_W, default $clog2(XLEN+1), iteration-counter width.
- REQ-003: clock  in  1  sole clock; all state updates on rising edge.
- REQ-004: reset  in  1  asynchronous, active-high reset.
- REQ-005: req_valid  in  1  operation offered.
- REQ-006: req_ready  out  1  unit can accept; high only in IDLE.
- REQ-007: req_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- REQ-008: req_lhs  in  XLEN  rs1 operand.
- REQ-009: req_rhs  in  XLEN  rs2 operand.
- REQ-010: flush  in  1  abort the in-flight operation.
- REQ-011: resp_valid  out  1  result available.
- REQ-012: resp_ready  in  1  consumer takes result.
- REQ-013: resp_data  out  XLEN  result.
- REQ-014: resp_illegal  out  1  op not supported in this build.
- REQ-015: busy  out  1  high in CALC or DONE.

Function
- REQ-016: The FSM SHALL have states IDLE, CALC and DONE.
- REQ-017: On req_valid && req_ready, the unit SHALL latch req_op and operand magnitudes plus result-sign flags, and SHALL enter CALC with the counter at XLEN.
- REQ-018: Special cases SHALL bypass CALC and go IDLE->DONE; resp_valid asserts the next cycle.
  - Divide by zero: quotient all-ones; remainder = lhs.
  - Signed overflow (lhs = 2^(XLEN-1), rhs = all-ones, DIV/REM): quotient = lhs; remainder = 0.
- REQ-019: Multiply SHALL be radix-2 shift-add on magnitudes, one bit per cycle, into a 2*XLEN product.
  - MULHSU treats only lhs as signed.
- REQ-020: Divide SHALL be restoring, one quotient bit per cycle.
  - Quotient sign = lhs sign XOR rhs sign; remainder sign = lhs sign.
- REQ-021: CALC SHALL last exactly XLEN cycles. With a handshake at edge 0, resp_valid SHALL be high from cycle XLEN+1.
- REQ-022: Sign correction (two's-complement negate) SHALL be applied on the CALC->DONE edge.
- REQ-023: Result selection:
  - MUL: low XLEN bits of product.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- REQ-024: In DONE, resp_valid SHALL be 1, and resp_data/resp_illegal SHALL stay stable until resp_ready.
- REQ-025: DONE with resp_ready SHALL return to IDLE. req_ready SHALL rise the following cycle; there is no same-cycle re-accept.
- REQ-026: flush SHALL force IDLE on the next edge from any state, producing no response, and SHALL take priority over resp_ready and over a new request.
- REQ-027: A request offered while not in IDLE SHALL be ignored and not latched.
- REQ-028: resp_data SHALL be 0 whenever resp_valid is 0.

Reset
- REQ-029: reset SHALL asynchronously force IDLE, counter 0, and all datapath registers 0.
- REQ-030: During and after reset the outputs SHALL be: req_ready=1, resp_valid=0, resp_data=0, resp_illegal=0, busy=0.
- REQ-031: Reset asserted mid-CALC SHALL discard the operation; no response SHALL follow release.

Configuration
- REQ-032: Macro EXU_MDU_DIV_EN SHALL include the divider datapath and the REQ-018 special cases.
- REQ-033: Without EXU_MDU_DIV_EN, ops 4-7 SHALL still be accepted and go IDLE->DONE.
  - Response: resp_data=0, resp_illegal=1, resp_valid one cycle after accept.
  - Multiply behaviour SHALL be unchanged.

Verification (XLEN=32)
- REQ-034: MUL 7 x 0xFFFFFFFD -> resp_data 0xFFFFFFEB, resp_valid first high 33 cycles after accept; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- REQ-035: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 0 -> 0xFFFFFFFF after 1 cycle; REMU 100 / 0 -> 100.
- REQ-036: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in 1 cycle; REM -> 0; without EXU_MDU_DIV_EN, DIV 10 / 2 -> resp_data 0, resp_illegal 1.
- REQ-037: resp_ready held 0 for 5 cycles in DONE -> resp_data constant and req_ready 0 throughout; req_valid pulsed meanwhile not latched.
- REQ-038: flush at CALC cycle 10 -> IDLE next edge, req_ready 1, no resp_valid; the next MUL 3 x 4 -> 12.
- REQ-039: reset pulsed at CALC cycle 5 -> all outputs at reset values immediately; no response after release.

Source files
------------

// File: rtl/exu_mdu.sv
// exu_mdu: iterative multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Optional macro EXU_MDU_DIV_EN adds the divider datapath; without it ops 4-7 respond illegal.
`default_nettype none

module exu_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic [XLEN-1:0] req_lhs_i,
    input  logic [XLEN-1:0] req_rhs_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_data_o,
    output logic            resp_illegal_o,
    output logic            busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              ill_q, ill_d;

    // Operand signedness: MUL/MULH/DIV/REM both signed, MULHSU lhs only.
    logic            w_lhs_signed, w_rhs_signed, w_lhs_neg, w_rhs_neg;
    logic [XLEN-1:0] w_lhs_mag, w_rhs_mag;

    assign w_lhs_signed = (req_op_i == 3'd0) || (req_op_i == 3'd1) || (req_op_i == 3'd2) ||
                          (req_op_i == 3'd4) || (req_op_i == 3'd6);
    assign w_rhs_signed = (req_op_i == 3'd0) || (req_op_i == 3'd1) ||
                          (req_op_i == 3'd4) || (req_op_i == 3'd6);
    assign w_lhs_neg    = w_lhs_signed & req_lhs_i[XLEN-1];
    assign w_rhs_neg    = w_rhs_signed & req_rhs_i[XLEN-1];
    assign w_lhs_mag    = w_lhs_neg ? -req_lhs_i : req_lhs_i;
    assign w_rhs_mag    = w_rhs_neg ? -req_rhs_i : req_rhs_i;

    // prod_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next, w_step, w_prod_cor;
    logic [XLEN-1:0]   w_mul_res, w_div_res, w_result;

    assign w_mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, prod_q[XLEN-1:1]};
    assign w_prod_cor = neg_q ? -w_step : w_step;
    assign w_mul_res  = (op_q[1:0] == 2'b00) ? w_prod_cor[XLEN-1:0] : w_prod_cor[2*XLEN-1:XLEN];

`ifdef EXU_MDU_DIV_EN
    logic              rneg_q, rneg_d;
    logic [XLEN:0]     w_div_shift, w_div_diff;
    logic [2*XLEN-1:0] w_div_next;
    logic [XLEN-1:0]   w_quo, w_rem;
    logic              w_div_zero, w_div_ovf;

    assign w_div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, b_q};
    assign w_div_next  = w_div_diff[XLEN] ? {w_div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                          : {w_div_diff[XLEN-1:0],  prod_q[XLEN-2:0], 1'b1};
    assign w_step      = op_q[2] ? w_div_next : w_mul_next;
    assign w_quo       = w_step[XLEN-1:0];
    assign w_rem       = w_step[2*XLEN-1:XLEN];
    assign w_div_res   = op_q[1] ? (rneg_q ? -w_rem : w_rem) : (neg_q ? -w_quo : w_quo);
    assign w_div_zero  = (req_rhs_i == '0);
    assign w_div_ovf   = ~req_op_i[0] && (req_lhs_i == {1'b1, {(XLEN-1){1'b0}}}) && (req_rhs_i == '1);
`else
    assign w_step      = w_mul_next;
    assign w_div_res   = '0;
`endif

    assign w_result = op_q[2] ? w_div_res : w_mul_res;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        prod_d  = prod_q;
        b_d     = b_q;
        neg_d   = neg_q;
        res_d   = res_q;
        ill_d   = ill_q;
`ifdef EXU_MDU_DIV_EN
        rneg_d  = rneg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    prod_d  = {{XLEN{1'b0}}, w_lhs_mag};
                    b_d     = w_rhs_mag;
                    neg_d   = w_lhs_neg ^ w_rhs_neg;
                    cnt_d   = CNT_W'(XLEN);
                    ill_d   = 1'b0;
                    state_d = S_CALC;
`ifdef EXU_MDU_DIV_EN
                    rneg_d  = w_lhs_neg;
                    if (req_op_i[2] && w_div_zero) begin
                        res_d   = req_op_i[1] ? req_lhs_i : {XLEN{1'b1}};
                        state_d = S_DONE;
                    end else if (req_op_i[2] && w_div_ovf) begin
                        res_d   = req_op_i[1] ? {XLEN{1'b0}} : req_lhs_i;
                        state_d = S_DONE;
                    end
`else
                    if (req_op_i[2]) begin
                        res_d   = '0;
                        ill_d   = 1'b1;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                prod_d = w_step;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res_d   = w_result;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush wins over completion and over a new request.
        if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            prod_q  <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            prod_q  <= prod_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            ill_q   <= ill_d;
        end
    end

`ifdef EXU_MDU_DIV_EN
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) rneg_q <= 1'b0;
        else         rneg_q <= rneg_d;
    end
`endif

    assign req_ready_o    = (state_q == S_IDLE);
    assign busy_o         = (state_q != S_IDLE);
    assign resp_valid_o   = (state_q == S_DONE);
    assign resp_data_o    = resp_valid_o ? res_q : '0;
    assign resp_illegal_o = resp_valid_o & ill_q;

endmodule

`default_nettype wire

// File: tb/tb_exu_mdu.sv
// tb_exu_mdu: directed self-checking bench for exu_mdu (XLEN=32).
`default_nettype none

module tb_exu_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, flush, resp_valid, resp_ready, resp_illegal, busy;
    logic [2:0]  req_op;
    logic [31:0] req_lhs, req_rhs, resp_data;

    int n_tests = 0;
    int n_fail  = 0;

    exu_mdu #(.XLEN(32)) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_lhs_i      (req_lhs),
        .req_rhs_i      (req_rhs),
        .flush_i        (flush),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_data_o    (resp_data),
        .resp_illegal_o (resp_illegal),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":req_ready"},    64'(req_ready),    64'd1);
        check({tag, ":resp_valid"},   64'(resp_valid),   64'd0);
        check({tag, ":resp_data"},    64'(resp_data),    64'd0);
        check({tag, ":resp_illegal"}, 64'(resp_illegal), 64'd0);
        check({tag, ":busy"},         64'(busy),         64'd0);
    endtask

    // Latency counts edges from the accepting edge until resp_valid is seen.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic exp_ill,
                          input int exp_lat);
        int n;
        check({tag, ":ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = op; req_lhs = a; req_rhs = b;
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, ":latency"}, 64'(n), 64'(exp_lat));
        check({tag, ":data"},    64'(resp_data), 64'(exp));
        check({tag, ":illegal"}, 64'(resp_illegal), 64'(exp_ill));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, ":drained"}, 64'(resp_valid), 64'd0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (resp_valid) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_lhs = '0; req_rhs = '0;
        flush = 1'b0; resp_ready = 1'b0;
        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check_reset_outputs("post_reset");

        run_op("mul_7xm3",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33);
        run_op("mulhu_max",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
        run_op("mul_big",      3'd0, 32'd12345,    32'd6789,     32'h04FED79D, 1'b0, 33);
        run_op("mulh_min",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33);
        run_op("mulh_m2x3",    3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0, 33);
        run_op("mulh_m1xm1",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33);
        run_op("mulhsu_m1",    3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33);
`ifdef EXU_MDU_DIV_EN
        run_op("div_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33);
        run_op("rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33);
        run_op("divu_100_7",   3'd5, 32'd100,      32'd7,        32'd14,       1'b0, 33);
        run_op("remu_100_7",   3'd7, 32'd100,      32'd7,        32'd2,        1'b0, 33);
        run_op("divu_by0",     3'd5, 32'd100,      32'd0,        32'hFFFFFFFF, 1'b0, 1);
        run_op("remu_by0",     3'd7, 32'd100,      32'd0,        32'd100,      1'b0, 1);
        run_op("div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
        run_op("rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1);
`else
        run_op("div_illegal",  3'd4, 32'd10,       32'd2,        32'd0,        1'b1, 1);
        run_op("remu_illegal", 3'd7, 32'd5,        32'd3,        32'd0,        1'b1, 1);
`endif

        // Backpressure in DONE with a competing request that must not be taken.
        req_valid = 1'b1; req_op = 3'd0; req_lhs = 32'd3; req_rhs = 32'd5;
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 100) begin
            tick();
            n++;
        end
        check("stall:latency", 64'(n), 64'd33);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_op = 3'd3; req_lhs = 32'd9; req_rhs = 32'd9;
            tick();
            check("stall:data",      64'(resp_data), 64'd15);
            check("stall:req_ready", 64'(req_ready), 64'd0);
            check("stall:valid",     64'(resp_valid), 64'd1);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("stall:back_idle", 64'(req_ready), 64'd1);
        check("stall:busy",      64'(busy),      64'd0);
        quiet("stall:no_ghost", 40);

        // Flush mid-computation.
        req_valid = 1'b1; req_op = 3'd0; req_lhs = 32'd11; req_rhs = 32'd13;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("flush:busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush:req_ready",  64'(req_ready),  64'd1);
        check("flush:resp_valid", 64'(resp_valid), 64'd0);
        check("flush:busy",       64'(busy),       64'd0);
        quiet("flush:no_resp", 40);
        run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0, 33);

        // Asynchronous reset mid-computation.
        req_valid = 1'b1; req_op = 3'd3; req_lhs = 32'd21; req_rhs = 32'd2;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("after_release");
        quiet("reset:no_resp", 40);
        run_op("mul_after_reset", 3'd0, 32'd6, 32'd7, 32'd42, 1'b0, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
